// File: rtl/router_pkg.sv
// Shared constants and types for the router register block and its FSM.
package router_pkg;

  // Default byte width of the packet stream.
  localparam int DATA_W_DEF = 8;

  // Destination address value that marks a header as invalid.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // One-hot state strobes driven by r_fsm into r_reg.
  typedef struct packed {
    logic detect_add;
    logic lfd;
    logic ld;
    logic laf;
    logic full;
  } state_strobes_t;

endpackage

// File: rtl/r_parity_chk.sv
// Packet parity checker: accumulates the running XOR of header/payload bytes,
// captures the parity byte sent by the source and flags a mismatch one
// cycle after capture. The flag is sticky until the next clear.
module r_parity_chk
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              xor_en,
  input  logic [DATA_W-1:0] xor_data,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] cap_data,
  output logic              err
);

  logic [DATA_W-1:0] r_int_par;
  logic [DATA_W-1:0] r_pkt_par;
  logic              r_cap_d;
  logic              r_err;

  // Accumulate, capture, then compare on the cycle after capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_int_par <= '0;
      r_pkt_par <= '0;
      r_cap_d   <= 1'b0;
      r_err     <= 1'b0;
    end else if (clear) begin
      r_int_par <= '0;
      r_pkt_par <= '0;
      r_cap_d   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (xor_en) r_int_par <= r_int_par ^ xor_data;
      if (cap_en) r_pkt_par <= cap_data;
      r_cap_d <= cap_en;
      if (r_cap_d && (r_int_par != r_pkt_par)) r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: rtl/r_reg.sv
// Router register block: latches the packet header, stages bytes toward the
// destination FIFO, holds the byte that arrived while the FIFO was full and
// tracks packet parity.
//
// Stream semantics: the source presents one byte per cycle in data_in with
// pkt_valid high for header/payload and low for the trailing parity byte.
// fifo_full is a backpressure flag sampled in ld_state: a byte arriving while
// it is high is parked in the full-state byte and replayed in laf_state.
module r_reg
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic              parity_done,
  output logic              low_packet_valid,
  output logic              err,
  output logic [DATA_W-1:0] dout
);

  state_strobes_t    w_st;
  logic              w_hdr_load;
  logic              w_pd_set_ld;
  logic              w_pd_set_laf;
  logic              w_xor_en;
  logic [DATA_W-1:0] w_xor_data;
  logic [DATA_W-1:0] w_cap_data;
  logic [DATA_W-1:0] r_hdr;
  logic [DATA_W-1:0] r_fsb;

  assign w_st = {detect_add, lfd_state, ld_state, laf_state, full_state};

  // Invalid addresses never overwrite the stored header.
  assign w_hdr_load   = w_st.detect_add && pkt_valid && (data_in[1:0] != ADDR_INVALID);
  // Parity byte taken straight from the stream when the FIFO can accept it.
  assign w_pd_set_ld  = w_st.ld && !fifo_full && !pkt_valid;
  // Parity byte replayed from the full-state byte after backpressure.
  assign w_pd_set_laf = w_st.laf && low_packet_valid && !parity_done;

  assign w_xor_en   = w_st.lfd || (w_st.ld && pkt_valid && !w_st.full);
  assign w_xor_data = w_st.lfd ? r_hdr : data_in;
  assign w_cap_data = w_pd_set_ld ? data_in : r_fsb;

  // Header and full-state byte capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hdr <= '0;
      r_fsb <= '0;
    end else begin
      if (w_hdr_load) r_hdr <= data_in;
      if (w_st.ld && fifo_full) r_fsb <= data_in;
    end
  end

  // Output byte selection toward the destination FIFO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout <= '0;
    end else if (w_st.lfd) begin
      dout <= r_hdr;
    end else if (w_st.ld && !fifo_full) begin
      dout <= data_in;
    end else if (w_st.laf) begin
      dout <= r_fsb;
    end
  end

  // low_packet_valid: FSM clear wins over the set from a dropped pkt_valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      low_packet_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_packet_valid <= 1'b0;
    end else if (w_st.ld && !pkt_valid) begin
      low_packet_valid <= 1'b1;
    end
  end

  // parity_done: cleared per packet, set when the parity byte is captured.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity_done <= 1'b0;
    end else if (w_st.detect_add) begin
      parity_done <= 1'b0;
    end else if (w_pd_set_ld || w_pd_set_laf) begin
      parity_done <= 1'b1;
    end
  end

  r_parity_chk #(
    .DATA_W(DATA_W)
  ) u_parity_chk (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (w_st.detect_add),
    .xor_en  (w_xor_en),
    .xor_data(w_xor_data),
    .cap_en  (w_pd_set_ld || w_pd_set_laf),
    .cap_data(w_cap_data),
    .err     (err)
  );

endmodule

// File: doc/r_reg.md
R_REG -- requirements
Module: r_reg

Interface
REQ-001 Parameter DATA_W, default 8, width of data_in/dout and of the internal byte registers.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 pkt_valid  input  1  source marks header/payload bytes; low on the parity byte.
REQ-005 data_in  input  DATA_W  packet byte stream: header, payload, then parity.
REQ-006 fifo_full  input  1  selected destination FIFO full this cycle.
REQ-007 detect_add, lfd_state, ld_state, laf_state, full_state  input  1 each  one-hot FSM state strobes.
REQ-008 rst_int_reg  input  1  FSM request to clear low_packet_valid.
REQ-009 parity_done  output  1  packet parity byte captured.
REQ-010 low_packet_valid  output  1  pkt_valid dropped while loading.
REQ-011 err  output  1  parity mismatch for the current packet.
REQ-012 dout  output  DATA_W  byte presented to the destination FIFO.

Function
REQ-013 Header register SHALL load data_in when detect_add && pkt_valid && data_in[1:0] != 2'b11; otherwise hold.
REQ-014 dout SHALL load: header register if lfd_state; data_in if ld_state && !fifo_full; FSB if laf_state; else hold.
REQ-015 Full-state byte (FSB) SHALL load data_in when ld_state && fifo_full; else hold.
REQ-016 low_packet_valid: cleared by rst_int_reg (highest priority); set when ld_state && !pkt_valid; else hold.
REQ-017 parity_done: cleared on detect_add; set when (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_packet_valid && !parity_done); else hold.
REQ-018 Internal parity (DATA_W bits): cleared on detect_add; XOR header register on lfd_state; XOR data_in on ld_state && pkt_valid && !full_state.
REQ-019 Packet parity: cleared on detect_add; loads data_in with the parity_done set of the ld_state branch; loads FSB with the set of the laf_state branch.
REQ-020 err: cleared on detect_add; set one cycle after parity_done rises if internal parity != packet parity; then held until next detect_add.
REQ-021 Latency: each byte appears on dout exactly one clock after its enabling strobe.
REQ-022 Only one state strobe is active per cycle; with none active all registers hold.
REQ-023 Invalid address (data_in[1:0]==2'b11) SHALL leave header register and parity state unchanged apart from the detect_add clears.

Reset
REQ-024 resetn low SHALL immediately clear dout, parity_done, low_packet_valid, err, header register, FSB, internal and packet parity to 0, including mid-packet.
REQ-025 After resetn deasserts, first update occurs on the next rising clk edge.

Structure
REQ-026 Package router_pkg SHALL hold DATA_W default, ADDR_INVALID = 2'b11 and the state-strobe bundle typedef shared with r_fsm.
REQ-027 Parity accumulation/compare SHALL be one sub-module, r_parity_chk (clear, xor_en, xor_data, cap_en, cap_data -> err).
REQ-028 Total RTL 120-400 lines, no latches, no multicycle paths.

Verification
REQ-029 Header 8'h05, payload 8'hA5, parity 8'hA0 through lfd/ld -> dout 05, A5, A0 in sequence; parity_done=1; err=0.
REQ-030 Same packet with parity 8'h00 -> parity_done=1, err=1 one cycle later, err cleared at next detect_add.
REQ-031 fifo_full=1 on payload 8'h3C during ld_state, then laf_state -> dout=8'h3C one cycle after laf_state; internal parity includes 3C once.
REQ-032 detect_add with data_in=8'h07 (addr 3) -> header register keeps prior value; lfd_state then drives old header.
REQ-033 pkt_valid low in ld_state plus rst_int_reg same cycle -> low_packet_valid stays 0.
REQ-034 resetn pulsed low mid-payload -> all outputs 0 asynchronously; next packet 8'h06/8'h11/8'h17 completes with err=0.
